// File: rtl/relu_requant.sv
`default_nettype none
// ============================================================================
// Module   : relu_requant
// Purpose  : Post-bias activation stage. Applies ReLU, a rounding right-shift
//            requantization and unsigned saturation to a signed accumulator,
//            producing unsigned activations. Two-stage valid/ready pipeline
//            with full backpressure and a per-frame last-word flag.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_valid/i_ready - input handshake
//            i_acc_bias      - signed bias-added accumulator (AB_BW)
//            i_shift         - requant shift, sampled with i_acc_bias
//            o_valid/o_ready - output handshake
//            o_act           - unsigned quantized activation (OUT_BW)
//            o_last          - marks the final activation of a frame
// Revision : 1.0 - initial release
// ============================================================================
module relu_requant #(
    parameter int AB_BW     = 25,
    parameter int OUT_BW    = 8,
    parameter int SH_BW     = 5,
    parameter int FRAME_LEN = 25,
    parameter int CNT_BW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [AB_BW-1:0]  i_acc_bias,
    input  logic [SH_BW-1:0]  i_shift,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [OUT_BW-1:0] o_act,
    output logic              o_last
);

    // One extra bit so the rounding addend can never overflow.
    localparam int                EXT_BW     = AB_BW + 1;
    localparam logic [CNT_BW-1:0] C_LAST_IDX = CNT_BW'(FRAME_LEN - 1);
    localparam logic [EXT_BW-1:0] C_SAT_MAX  = EXT_BW'((1 << OUT_BW) - 1);

    logic              r_s1_valid;
    logic [EXT_BW-1:0] r_s1_q;
    logic              r_s2_valid;
    logic [OUT_BW-1:0] r_act;
    logic              r_last;
    logic [CNT_BW-1:0] r_cnt;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [AB_BW-1:0]  w_relu;
    logic [EXT_BW-1:0] w_half;
    logic [EXT_BW-1:0] w_sum;
    logic [EXT_BW-1:0] w_q;
    logic [OUT_BW-1:0] w_sat;
    logic [CNT_BW-1:0] w_cnt_inc;
    logic [CNT_BW-1:0] w_load_idx;

    // Ready depends only on pipeline occupancy and o_ready, never on i_valid.
    assign w_s2_adv = !r_s2_valid || o_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign i_ready  = w_s1_adv;

    // Stage 1 datapath: ReLU then round-half-up right shift. A zero shift
    // gets a zero addend, so the same shifter path covers it. Out-of-range
    // shifts simply produce some value; control flow is unaffected.
    assign w_relu = i_acc_bias[AB_BW-1] ? '0 : i_acc_bias;
    assign w_half = (i_shift == '0) ? '0 : (EXT_BW'(1) << (i_shift - SH_BW'(1)));
    assign w_sum  = {1'b0, w_relu} + w_half;
    assign w_q    = w_sum >> i_shift;

    // Stage 2 datapath: unsigned saturation.
    assign w_sat = (r_s1_q > C_SAT_MAX) ? '1 : r_s1_q[OUT_BW-1:0];

    // r_cnt is the in-frame index of the word currently held in stage 2.
    // A word loaded while the held word is being consumed takes the next
    // index; a word loaded into an empty stage takes r_cnt itself.
    assign w_cnt_inc  = (r_cnt == C_LAST_IDX) ? '0 : r_cnt + CNT_BW'(1);
    assign w_load_idx = r_s2_valid ? w_cnt_inc : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_q     <= '0;
            r_s2_valid <= 1'b0;
            r_act      <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= i_valid;
                if (i_valid) begin
                    r_s1_q <= w_q;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_act  <= w_sat;
                    r_last <= (w_load_idx == C_LAST_IDX);
                end
            end
            if (r_s2_valid && o_ready) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_valid = r_s2_valid;
    assign o_act   = r_act;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_relu_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_requant
// Purpose  : Self-checking bench for relu_requant (FRAME_LEN=4 instance).
//            A queue-based reference model predicts every output word and its
//            frame-last flag; directed vectors pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_requant;

    localparam int C_FL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [24:0] i_acc_bias = '0;
    logic [4:0]  i_shift = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [7:0]  o_act;
    logic        o_last;

    int checks = 0;
    int errors = 0;

    relu_requant #(.FRAME_LEN(C_FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_acc_bias (i_acc_bias),
        .i_shift    (i_shift),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_act      (o_act),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the activation rules.
    function automatic int model_act(input longint x, input int sh);
        longint r, q;
        r = (x < 0) ? 0 : x;
        if (sh > 0) q = (r + (longint'(1) << (sh - 1))) >> sh;
        else        q = r;
        return (q > 255) ? 255 : int'(q);
    endfunction

    // ---------------- model + compare process (negedge) ----------------
    int          exp_q[$];
    int          out_seen = 0;
    logic [31:0] last_mask = '0;
    bit          prev_stall = 0;
    bit          post_rst = 0;
    logic [7:0]  prev_act;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            out_seen   = 0;
            last_mask  = '0;
            prev_stall = 0;
            post_rst   = 1;
        end else begin
            if (post_rst) begin
                checks++;
                if (o_valid !== 1'b0 || o_act !== 8'd0 || o_last !== 1'b0 || i_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_state: valid=%b act=%0d last=%b i_ready=%b, want 0/0/0/1",
                             o_valid, o_act, o_last, i_ready);
                end
                post_rst = 0;
            end
            if (prev_stall) begin
                checks++;
                if (o_valid !== 1'b1 || o_act !== prev_act || o_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b act=%0d last=%b, want 1/%0d/%b",
                             o_valid, o_act, o_last, prev_act, prev_last);
                end
            end
            if (o_valid && o_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output: got act=%0d, want no output", o_act);
                end else begin
                    int  e;
                    bit  el;
                    e  = exp_q.pop_front();
                    el = ((out_seen % C_FL) == C_FL - 1);
                    if (o_act !== 8'(e) || o_last !== el) begin
                        errors++;
                        $display("FAIL out_word%0d: act=%0d last=%b, want act=%0d last=%b",
                                 out_seen, o_act, o_last, e, el);
                    end
                end
                if (o_last && out_seen < 32) last_mask[out_seen] = 1'b1;
                out_seen++;
            end
            if (i_valid && i_ready)
                exp_q.push_back(model_act(longint'($signed(i_acc_bias)), int'(i_shift)));
            prev_stall = o_valid && !o_ready;
            prev_act   = o_act;
            prev_last  = o_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Pipeline must be empty with o_ready=1; result appears 2 clocks after accept.
    task automatic send_check(input int x, input int sh, input int want, input string name);
        i_valid    = 1'b1;
        i_acc_bias = 25'(x);
        i_shift    = 5'(sh);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, "_valid"}, int'(o_valid), 1);
        chk(name, int'(o_act), want);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_cnt;
        int next_val;
        int guard;
        int base;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic vectors.
        o_ready = 1'b1;
        send_check(-100,    4, 0,   "neg_relu");
        send_check(1000,    4, 63,  "round_1000");
        send_check(1048575, 4, 255, "saturate");
        send_check(24,      4, 2,   "round_half_up");
        send_check(200,     0, 200, "sh0_200");
        send_check(300,     0, 255, "sh0_sat");
        send_check(0,       0, 0,   "sh0_zero");

        // Frame flag: 9 outputs at full rate -> last on 4th and 8th.
        do_reset();
        o_ready = 1'b1;
        i_shift = 5'd0;
        for (int v = 1; v <= 9; v++) begin
            i_valid    = 1'b1;
            i_acc_bias = 25'(v);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("frame_count", out_seen, 9);
        chk("frame_last_mask", int'(last_mask), 32'h88);

        // Reset with two words in flight: they must vanish, frame restarts.
        o_ready    = 1'b0;
        i_valid    = 1'b1;
        i_acc_bias = 25'd50;
        @(posedge clk); #1;
        i_acc_bias = 25'd60;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("stalled_valid", int'(o_valid), 1);
        do_reset();
        chk("valid_after_rst", int'(o_valid), 0);
        o_ready = 1'b1;
        for (int v = 7; v <= 10; v++) begin
            i_valid    = 1'b1;
            i_acc_bias = 25'(v);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("fresh_count", out_seen, 4);
        chk("fresh_last_mask", int'(last_mask), 32'h8);

        // Backpressure: stage fills with 2 words, then i_ready drops.
        base       = out_seen;
        o_ready    = 1'b0;
        i_valid    = 1'b1;
        i_shift    = 5'd0;
        next_val   = 1;
        i_acc_bias = 25'(next_val);
        acc_cnt    = 0;
        repeat (5) begin
            @(negedge clk);
            if (i_ready) acc_cnt++;
            @(posedge clk); #1;
            if (acc_cnt >= next_val) begin
                next_val++;
                i_acc_bias = 25'(next_val);
            end
        end
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_i_ready", int'(i_ready), 0);

        // Remaining words 3..10 with random 50% o_ready.
        guard = 0;
        while (next_val <= 10 && guard < 500) begin
            o_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i_ready) next_val++;
            @(posedge clk); #1;
            if (next_val <= 10) i_acc_bias = 25'(next_val);
            else                i_valid = 1'b0;
            guard++;
        end
        i_valid = 1'b0;
        chk("bp_stream_done", int'(guard < 500), 1);
        o_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_out_count", out_seen - base, 10);
        chk("bp_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
